// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: two-slot scoreboard of in-flight writes (EX, MEM)
// driving stall, branch-operand forwarding, IF/ID flush and a saturating stall counter.
module id_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic [4:0]       id_dest,
  input  logic             pc_src,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             forwardC,
  output logic             forwardD,
  output logic             flush_ifid,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             ex_v_q, ex_v_d, ex_wr_q, ex_wr_d, ex_ld_q, ex_ld_d;
  logic [4:0]       ex_dst_q, ex_dst_d;
  logic             mem_v_q, mem_v_d, mem_wr_q, mem_wr_d, mem_ld_q, mem_ld_d;
  logic [4:0]       mem_dst_q, mem_dst_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic ex_live_rs, ex_live_rt, mem_live_rs, mem_live_rt;
  logic ex_hit, mem_hit;

  // Register $0 is never a real dependency, so it never matches.
  function automatic logic slot_live(input logic v, input logic wr,
                                     input logic [4:0] dst, input logic [4:0] r);
    return v & wr & (dst == r) & (r != 5'd0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    ex_live_rs  = slot_live(ex_v_q, ex_wr_q, ex_dst_q, id_rs);
    ex_live_rt  = id_uses_rt & slot_live(ex_v_q, ex_wr_q, ex_dst_q, id_rt);
    mem_live_rs = slot_live(mem_v_q, mem_wr_q, mem_dst_q, id_rs);
    mem_live_rt = id_uses_rt & slot_live(mem_v_q, mem_wr_q, mem_dst_q, id_rt);
    ex_hit      = ex_live_rs | ex_live_rt;
    mem_hit     = mem_live_rs | mem_live_rt;
    // An EX hit always wins over MEM: with a branch it stalls, so no forward escapes.
    stall       = id_valid & ((ex_hit & (ex_ld_q | id_branch)) |
                              (id_branch & mem_hit & mem_ld_q));
    forwardC    = id_valid & id_branch & mem_live_rs & ~mem_ld_q & ~stall;
    forwardD    = id_valid & id_branch & mem_live_rt & ~mem_ld_q & ~stall;
    pc_write    = ~stall & ~freeze;
    ifid_write  = ~stall & ~freeze;
    flush_ifid  = pc_src & id_branch & id_valid & ~stall & ~freeze;
  end

  always_comb begin
    ex_v_d      = id_valid & ~stall;
    ex_wr_d     = id_regwrite;
    ex_ld_d     = id_memread;
    ex_dst_d    = id_dest;
    mem_v_d     = ex_v_q;
    mem_wr_d    = ex_wr_q;
    mem_ld_d    = ex_ld_q;
    mem_dst_d   = ex_dst_q;
    stall_cnt_d = (stall & ~freeze) ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  // Slot valid bits and the counter are the only state that needs reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v_q      <= 1'b0;
      mem_v_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else if (~freeze) begin
      ex_v_q      <= ex_v_d;
      mem_v_q     <= mem_v_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (~freeze) begin
      ex_wr_q   <= ex_wr_d;
      ex_ld_q   <= ex_ld_d;
      ex_dst_q  <= ex_dst_d;
      mem_wr_q  <= mem_wr_d;
      mem_ld_q  <= mem_ld_d;
      mem_dst_q <= mem_dst_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed pipeline scenarios with literal expectations,
// then random traffic checked every cycle against an in-bench scoreboard model.
module tb_id_hazard_ctrl;

  logic clk = 1'b0;
  logic rst, freeze, id_valid, id_uses_rt, id_branch, id_regwrite, id_memread, pc_src;
  logic [4:0] id_rs, id_rt, id_dest;
  logic stall, pc_write, ifid_write, forwardC, forwardD, flush_ifid;
  logic [15:0] stall_cnt;
  logic s8_stall, s8_pc_write, s8_ifid_write, s8_fwc, s8_fwd, s8_flush;
  logic [7:0] s8_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .freeze(freeze), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_branch(id_branch),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_dest(id_dest),
    .pc_src(pc_src), .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
    .forwardC(forwardC), .forwardD(forwardD), .flush_ifid(flush_ifid),
    .stall_cnt(stall_cnt)
  );

  id_hazard_ctrl #(.CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .freeze(freeze), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_branch(id_branch),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_dest(id_dest),
    .pc_src(pc_src), .stall(s8_stall), .pc_write(s8_pc_write), .ifid_write(s8_ifid_write),
    .forwardC(s8_fwc), .forwardD(s8_fwd), .flush_ifid(s8_flush),
    .stall_cnt(s8_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: the two most recently issued instructions still ahead of WB.
  typedef struct {
    bit       v;
    bit       wr;
    bit       ld;
    bit [4:0] dst;
  } slot_t;

  slot_t sb_ex, sb_mem, nx_ex, nx_mem;
  int    m_cnt = 0, m_cnt8 = 0, nx_cnt = 0, nx_cnt8 = 0;

  function automatic bit writes_reg(slot_t s, bit [4:0] r);
    return s.v && s.wr && s.dst == r && r != 0;
  endfunction

  bit       e_stall, f_rs, f_rt, e_fc, e_fd, e_pcw, e_flush;
  bit [4:0] src;

  always @(negedge clk) begin
    e_stall = 0; f_rs = 0; f_rt = 0;
    for (int k = 0; k < 2; k++) begin
      if (k == 1 && !id_uses_rt) continue;
      src = (k == 0) ? id_rs : id_rt;
      if (writes_reg(sb_ex, src)) begin
        if (sb_ex.ld || id_branch) e_stall = 1;
      end else if (writes_reg(sb_mem, src) && id_branch) begin
        if (sb_mem.ld) e_stall = 1;
        else if (k == 0) f_rs = 1;
        else f_rt = 1;
      end
    end
    e_stall = e_stall && id_valid;
    e_fc    = id_valid && f_rs && !e_stall;
    e_fd    = id_valid && f_rt && !e_stall;
    e_pcw   = !e_stall && !freeze;
    e_flush = pc_src && id_branch && id_valid && !e_stall && !freeze;
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("pc_write", 32'(pc_write), 32'(e_pcw));
      chk("ifid_write", 32'(ifid_write), 32'(e_pcw));
      chk("forwardC", 32'(forwardC), 32'(e_fc));
      chk("forwardD", 32'(forwardD), 32'(e_fd));
      chk("flush_ifid", 32'(flush_ifid), 32'(e_flush));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      chk("stall_cnt8", 32'(s8_cnt), 32'(m_cnt8));
      chk("stall8", 32'(s8_stall), 32'(e_stall));
    end
    nx_ex = sb_ex; nx_mem = sb_mem; nx_cnt = m_cnt; nx_cnt8 = m_cnt8;
    if (rst) begin
      nx_ex.v = 0; nx_mem.v = 0; nx_cnt = 0; nx_cnt8 = 0;
    end else if (!freeze) begin
      nx_mem = sb_ex;
      nx_ex.v = id_valid && !e_stall;
      nx_ex.wr = id_regwrite; nx_ex.ld = id_memread; nx_ex.dst = id_dest;
      if (e_stall) begin
        nx_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
        nx_cnt8 = (m_cnt8 < 255)   ? m_cnt8 + 1 : m_cnt8;
      end
    end
  end

  always @(posedge clk) begin
    sb_ex <= nx_ex; sb_mem <= nx_mem; m_cnt <= nx_cnt; m_cnt8 <= nx_cnt8;
  end

  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic br, input logic rw, input logic mr,
                      input logic [4:0] dst, input logic pcs, input logic fz, input logic rr);
    @(posedge clk);
    #1;
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_branch = br;
    id_regwrite = rw; id_memread = mr; id_dest = dst; pc_src = pcs; freeze = fz; rst = rr;
    #2;
  endtask

  task automatic bubble2();
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; freeze = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    id_branch = 0; id_regwrite = 0; id_memread = 0; id_dest = 0; pc_src = 0;
    sb_ex = '{0, 0, 0, 0}; sb_mem = '{0, 0, 0, 0};
    nx_ex = sb_ex; nx_mem = sb_mem;
    @(posedge clk);
    #1 chk_en = 1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fwc", 32'(forwardC), 0);
    chk("rst_fwd", 32'(forwardD), 0);
    chk("rst_flush", 32'(flush_ifid), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    chk("rst_pcw", 32'(pc_write), 1);
    chk("rst_ifidw", 32'(ifid_write), 1);

    // lw $2 ; add $3,$2,$4
    step(1, 1, 2, 0, 0, 1, 1, 2, 0, 0, 0);
    chk("lu_lw_stall", 32'(stall), 0);
    step(1, 2, 4, 1, 0, 1, 0, 3, 0, 0, 0);
    chk("lu_stall", 32'(stall), 1);
    chk("lu_pcw", 32'(pc_write), 0);
    step(1, 2, 4, 1, 0, 1, 0, 3, 0, 0, 0);
    chk("lu_release", 32'(stall), 0);
    chk("lu_cnt", 32'(stall_cnt), 1);

    // add $5,$1,$1 ; beq $5,$6 taken
    bubble2();
    step(1, 1, 1, 1, 0, 1, 0, 5, 0, 0, 0);
    step(1, 5, 6, 1, 1, 0, 0, 0, 1, 0, 0);
    chk("br_alu_stall1", 32'(stall), 1);
    chk("br_alu_fwc1", 32'(forwardC), 0);
    chk("br_alu_flush1", 32'(flush_ifid), 0);
    step(1, 5, 6, 1, 1, 0, 0, 0, 1, 0, 0);
    chk("br_alu_stall2", 32'(stall), 0);
    chk("br_alu_fwc2", 32'(forwardC), 1);
    chk("br_alu_fwd2", 32'(forwardD), 0);
    chk("br_alu_flush2", 32'(flush_ifid), 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("br_alu_flush3", 32'(flush_ifid), 0);

    // lw $7 ; bne $0,$7
    bubble2();
    step(1, 1, 7, 0, 0, 1, 1, 7, 0, 0, 0);
    step(1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("br_ld_stall1", 32'(stall), 1);
    step(1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("br_ld_stall2", 32'(stall), 1);
    step(1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("br_ld_stall3", 32'(stall), 0);
    chk("br_ld_fwd3", 32'(forwardD), 0);
    chk("br_ld_cnt", 32'(stall_cnt), 4);

    // writer of $0 ; beq $0,$0
    bubble2();
    step(1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    chk("r0_stall", 32'(stall), 0);
    chk("r0_fwc", 32'(forwardC), 0);
    chk("r0_fwd", 32'(forwardD), 0);
    chk("r0_flush1", 32'(flush_ifid), 1);
    step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("r0_flush0", 32'(flush_ifid), 0);

    // load-use with freeze held for the first three stall cycles
    bubble2();
    step(1, 1, 2, 0, 0, 1, 1, 2, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 2, 4, 1, 0, 1, 0, 3, 0, 1, 0);
      chk("fz_stall", 32'(stall), 1);
      chk("fz_cnt", 32'(stall_cnt), 4);
    end
    step(1, 2, 4, 1, 0, 1, 0, 3, 0, 0, 0);
    chk("fz_stall_after", 32'(stall), 1);
    chk("fz_cnt_after", 32'(stall_cnt), 4);
    step(1, 2, 4, 1, 0, 1, 0, 3, 0, 0, 0);
    chk("fz_release", 32'(stall), 0);
    chk("fz_cnt_done", 32'(stall_cnt), 5);

    // reset in the middle of a two-cycle load-branch stall
    bubble2();
    step(1, 1, 2, 0, 0, 1, 1, 2, 0, 0, 0);
    step(1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("rs_stall1", 32'(stall), 1);
    step(1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    chk("rs_stall_in_rst", 32'(stall), 1);
    step(1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("rs_stall_cleared", 32'(stall), 0);
    chk("rs_cnt_cleared", 32'(stall_cnt), 0);

    // self-dependent load-branch stream: two stalls in every three cycles
    repeat (400) step(1, 7, 0, 0, 1, 1, 1, 7, 0, 0, 0);
    chk("sat8_cnt", 32'(s8_cnt), 255);
    chk("sat16_cnt_live", 32'(stall_cnt > 16'd255), 1);

    repeat (3000) begin
      step($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           5'($urandom_range(0, 3)), 1'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
    end

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Hazard and stall controller for the five-stage pipeline's decode stage, which resolves branches in ID. It keeps a two-entry scoreboard of in-flight register writes (EX and MEM slots) and from it generates:
- the stall and bubble controls for PC, IF/ID and ID/EX;
- the `forwardC`/`forwardD` selects that route the MEM-stage ALU result into the branch comparator;
- the IF/ID flush on a taken branch.

It also counts stall cycles for performance monitoring.

## Interface
- `CNT_W`, default 16: width of the saturating stall-cycle counter.
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `freeze` in 1: global pipeline hold from memory. While high, the scoreboard and counter are held and all outputs keep their combinational meaning.
- `id_valid` in 1: the IF/ID register holds a real instruction, not a bubble.
- `id_rs` in 5: the instruction's `IR[25:21]`.
- `id_rt` in 5: the instruction's `IR[20:16]`.
- `id_uses_rt` in 1: the instruction reads `rt` as a source (R-type, store, branch).
- `id_branch` in 1: `Brancheq | Branchneq` for the ID instruction.
- `id_regwrite` in 1: the ID instruction writes a register.
- `id_memread` in 1: the ID instruction is a load.
- `id_dest` in 5: final destination register, after the RegDst mux.
- `pc_src` in 1: raw branch-taken signal from the ID comparator.
- `stall` out 1: holds PC and IF/ID and inserts a bubble into ID/EX.
- `pc_write` out 1: `~stall & ~freeze`.
- `ifid_write` out 1: `~stall & ~freeze`.
- `forwardC` out 1: branch operand rs is taken from MEMData.
- `forwardD` out 1: branch operand rt is taken from MEMData.
- `flush_ifid` out 1: zeroes IF/ID on the next edge. Equals `pc_src & id_branch & id_valid & ~stall & ~freeze`.
- `stall_cnt` out `CNT_W`: number of cycles with `stall & ~freeze`; saturates at all-ones.

## Operation
- Scoreboard slots are EX and MEM. Each slot holds `{v, wr, ld, dst[4:0]}`.
- A slot is *live for register r* when `v & wr & dst==r & r!=0`.
- The source set is `id_rs`, plus `id_rt` when `id_uses_rt` is high.
- Stall conditions (logical OR, evaluated only when `id_valid` is high):
  - Load-use: the EX slot is live with `ld=1` for any source.
  - Branch on an EX-slot ALU result: `id_branch` and the EX slot is live with `ld=0` for any source.
  - Branch on a MEM-slot load: `id_branch` and the MEM slot is live with `ld=1` for any source.
- Forwarding:
  - `forwardC = id_valid & id_branch & MEM live(ld=0) for id_rs & ~stall`.
  - `forwardD` is the same condition for `id_rt`, and additionally requires `id_uses_rt`.
- EX-over-MEM priority: if both slots are live for a source, the EX slot decides. This yields a stall, never a forward.
- WB writes are not tracked. The register file resolves WB-to-ID hazards.
- Resulting branch stall length: 1 cycle after an ALU producer, 2 cycles after a load producer (EX, then MEM).
- Scoreboard update on each edge where `~freeze`:
  - MEM ← EX.
  - EX ← `{id_valid & ~stall, id_regwrite, id_memread, id_dest}`; a stall inserts a bubble with `v=0`.
- On `freeze`: both slots and `stall_cnt` hold.
- On `rst`: all `v` bits clear and `stall_cnt` clears. `rst` has priority over `freeze`.
- A taken branch itself advances into EX normally. Only the instruction in IF is flushed.
- `pc_src` is ignored while `stall` is high, because the comparator operands are stale.

## Timing
- All outputs are combinational from the registered scoreboard and the current ID inputs. There are no registered outputs except `stall_cnt`.
- After reset:
  - `stall=0`, `forwardC=0`, `forwardD=0`, `flush_ifid=0`, `stall_cnt=0`.
  - `pc_write=ifid_write=1`, provided `freeze=0`.
- `stall_cnt` increments on the edge that ends a stalled, unfrozen cycle. At `2^CNT_W-1` it holds.
- `rst` asserted mid-stall: on the next edge the scoreboard is empty, so `stall` drops in the same cycle that `rst` deasserts.
- `freeze` mid-stall: `stall` stays high and the scoreboard does not advance. The total number of stall cycles is unchanged; only the wall-clock time extends.

## Test plan
- `lw $2` in ID, then `add $3,$2,$4`: exactly 1 cycle with `stall=1`; EX slot `v=0` on the next edge; `stall_cnt`=1.
- `add $5,$1,$1` then `beq $5,$6`:
  - cycle 1: `stall=1`, `forwardC=0`;
  - cycle 2: `stall=0`, `forwardC=1`;
  - with `pc_src=1`, `flush_ifid=1` in cycle 2 only.
- `lw $7` then `bne $0,$7`: `stall=1` for 2 cycles, then `forwardD=0`, because the WB path is used and MEM slot `ld` blocks forwarding.
- Producer writing `$0` followed by `beq $0,$0`: `stall=0`, `forwardC=forwardD=0`, `flush_ifid` follows `pc_src`.
- Load-use hazard with `freeze=1` for 3 cycles mid-stall: `stall` stays 1 and `stall_cnt` stays 0 until `freeze` drops, then reaches 1. Asserting `rst` during the stall clears `stall` the cycle after.
- Force 65 537 stalled cycles with `CNT_W=16`: `stall_cnt` saturates at 65535.
